// File: rtl/axis_merge4.sv
// Four-lane AXI-Stream merge with round-robin arbitration and optional packet locking.
// Each output beat is tagged on m_axis_tid with its source lane; one registered output stage.
module axis_merge4 #(
    parameter int unsigned DATA_W   = 32,
    parameter bit          PKT_MODE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W*4-1:0]   s_axis_tdata,
    input  logic [3:0]            s_axis_tlast,
    input  logic [3:0]            s_axis_tvalid,
    output logic [3:0]            s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [1:0]            m_axis_tid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic                locked;
    logic [1:0]          grant;
    logic [1:0]          last_ptr;

    logic                load;
    logic                rr_found;
    logic [1:0]          rr_sel;
    logic [1:0]          sel;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic                xfer;

    // The output register can take a new beat when it is empty or being drained.
    assign load = ~m_axis_tvalid | m_axis_tready;

    // Round-robin scan starting just after the lane that finished last.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && s_axis_tvalid[last_ptr + 2'(k)]) begin
                rr_sel   = last_ptr + 2'(k);
                rr_found = 1'b1;
            end
        end
    end

    assign sel       = locked ? grant : rr_sel;
    assign sel_valid = locked | rr_found;
    assign sel_last  = s_axis_tlast[sel];
    assign sel_data  = s_axis_tdata[DATA_W*sel +: DATA_W];

    // A locked lane sees ready even while idle; the gap simply stalls the merge.
    always_comb begin
        s_axis_tready = '0;
        if (rst_n && load && sel_valid) begin
            s_axis_tready[sel] = 1'b1;
        end
    end

    assign xfer = |(s_axis_tready & s_axis_tvalid);

    // Packet-lock FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= ARB_OPEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Packet-lock FSM: next state.
    always_comb begin
        state_nxt = state;
        if (xfer && PKT_MODE) begin
            state_nxt = sel_last ? ARB_OPEN : ARB_LOCKED;
        end
    end

    // Packet-lock FSM: outputs.
    always_comb begin
        locked = (state == ARB_LOCKED);
    end

    // Grant follows the packet in progress; last_ptr moves only when a packet (or beat) completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= 2'd0;
            last_ptr <= 2'd3;
        end else if (xfer) begin
            if (PKT_MODE) begin
                if (!sel_last) begin
                    grant <= sel;
                end else begin
                    last_ptr <= sel;
                end
            end else begin
                last_ptr <= sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data path is reset too, so a beat dropped by reset never reappears downstream.
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= 2'd0;
            m_axis_tlast  <= 1'b0;
        end else begin
            m_axis_tvalid <= xfer | (m_axis_tvalid & ~m_axis_tready);
            if (xfer) begin
                m_axis_tdata <= sel_data;
                m_axis_tid   <= sel;
                m_axis_tlast <= sel_last;
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(s_axis_tready));

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_axis_tvalid && !m_axis_tready) |=>
            (m_axis_tvalid && $stable({m_axis_tdata, m_axis_tid, m_axis_tlast})));

endmodule

// File: tb/tb_axis_merge4.sv
// Directed and randomized checks of axis_merge4 in packet mode, plus a beat-mode
// instance for plain round-robin ordering.
module tb_axis_merge4;

    localparam int DW = 32;
    localparam int N_RAND = 10000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [DW*4-1:0] s_tdata = '0;
    logic [3:0]      s_tlast = '0;
    logic [3:0]      s_tvalid = '0;
    logic            m_tready = 1'b1;

    logic [3:0]      p_ready, b_ready;
    logic [DW-1:0]   p_data, b_data;
    logic [1:0]      p_tid, b_tid;
    logic            p_last, b_last, p_valid, b_valid;
    logic [35:0]     p_out, b_out;

    int passed = 0;
    int total  = 0;

    logic [32:0] exp_q [4][$];

    always #5 clk = ~clk;

    assign p_out = {p_valid, p_tid, p_last, p_data};
    assign b_out = {b_valid, b_tid, b_last, b_data};

    axis_merge4 #(.DATA_W(DW), .PKT_MODE(1'b1)) dut_pkt (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (p_ready),
        .m_axis_tdata  (p_data),
        .m_axis_tid    (p_tid),
        .m_axis_tlast  (p_last),
        .m_axis_tvalid (p_valid),
        .m_axis_tready (m_tready)
    );

    axis_merge4 #(.DATA_W(DW), .PKT_MODE(1'b0)) dut_beat (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (b_ready),
        .m_axis_tdata  (b_data),
        .m_axis_tid    (b_tid),
        .m_axis_tlast  (b_last),
        .m_axis_tvalid (b_valid),
        .m_axis_tready (m_tready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [31:0] d, input logic l);
        s_tdata[i*DW +: DW] = d;
        s_tvalid[i] = v;
        s_tlast[i]  = l;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        rst_n    = 1'b0;
        s_tvalid = 4'b1111;
        m_tready = 1'b1;
        #2;
        total++;
        if (p_out !== 36'h0) $display("FAIL reset_pkt_out: got %h expected %h", p_out, 36'h0);
        else passed++;
        total++;
        if (b_out !== 36'h0) $display("FAIL reset_beat_out: got %h expected %h", b_out, 36'h0);
        else passed++;
        total++;
        if ({p_ready, b_ready} !== 8'h00) $display("FAIL reset_ready: got %b expected %b", {p_ready, b_ready}, 8'h00);
        else passed++;
        tick();
        total++;
        if (p_out !== 36'h0) $display("FAIL reset_held_out: got %h expected %h", p_out, 36'h0);
        else passed++;
        s_tvalid = '0;
        rst_n = 1'b1;
        tick();
        total++;
        if (p_valid !== 1'b0) $display("FAIL reset_release_idle: got %b expected %b", p_valid, 1'b0);
        else passed++;
    endtask

    task automatic test_rr_beat();
        logic [3:0]  exp_rdy;
        logic [31:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 32'hC0DE_0000 + 32'(i), 1'b1);
        #1;
        total++;
        if ({b_valid, b_ready} !== 5'b0_0001) $display("FAIL rr_first_hs: got %b expected %b", {b_valid, b_ready}, 5'b0_0001);
        else passed++;
        for (int n = 0; n < 8; n++) begin
            tick();
            exp_d = 32'hC0DE_0000 + 32'(n % 4);
            total++;
            if (b_out !== {1'b1, 2'(n % 4), 1'b1, exp_d})
                $display("FAIL rr_beat%0d: got %h expected %h", n, b_out, {1'b1, 2'(n % 4), 1'b1, exp_d});
            else passed++;
            exp_rdy = 4'b0001 << ((n + 1) % 4);
            total++;
            if (b_ready !== exp_rdy) $display("FAIL rr_ready%0d: got %b expected %b", n, b_ready, exp_rdy);
            else passed++;
        end
        // Beat mode ignores tlast=0 and keeps alternating.
        s_tvalid = 4'b0011;
        s_tlast  = 4'b0000;
        for (int n = 0; n < 3; n++) begin
            tick();
            exp_d = 32'hC0DE_0000 + 32'(n % 2);
            total++;
            if (b_out !== {1'b1, 2'(n % 2), 1'b0, exp_d})
                $display("FAIL rr_nolock%0d: got %h expected %h", n, b_out, {1'b1, 2'(n % 2), 1'b0, exp_d});
            else passed++;
        end
        s_tvalid = '0;
        tick();
    endtask

    task automatic test_packet_lock();
        do_reset();
        set_lane(1, 1'b1, 32'h1111_0001, 1'b1);
        tick();
        total++;
        if (p_out !== {1'b1, 2'd1, 1'b1, 32'h1111_0001}) $display("FAIL lock_pre: got %h expected %h", p_out, {1'b1, 2'd1, 1'b1, 32'h1111_0001});
        else passed++;
        set_lane(0, 1'b1, 32'h0000_00A0, 1'b1);
        set_lane(1, 1'b1, 32'h0000_00B0, 1'b1);
        set_lane(2, 1'b1, 32'h0000_00C0, 1'b0);
        #1;
        total++;
        if (p_ready !== 4'b0100) $display("FAIL lock_rr_pick2: got %b expected %b", p_ready, 4'b0100);
        else passed++;
        tick();
        total++;
        if (p_out !== {1'b1, 2'd2, 1'b0, 32'h0000_00C0}) $display("FAIL lock_beat1: got %h expected %h", p_out, {1'b1, 2'd2, 1'b0, 32'h0000_00C0});
        else passed++;
        s_tvalid[2] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            #1;
            total++;
            if (p_ready !== 4'b0100) $display("FAIL lock_gap_ready%0d: got %b expected %b", n, p_ready, 4'b0100);
            else passed++;
            tick();
            total++;
            if (p_valid !== 1'b0) $display("FAIL lock_gap_valid%0d: got %b expected %b", n, p_valid, 1'b0);
            else passed++;
        end
        set_lane(2, 1'b1, 32'h0000_00C1, 1'b0);
        tick();
        total++;
        if (p_out !== {1'b1, 2'd2, 1'b0, 32'h0000_00C1}) $display("FAIL lock_beat2: got %h expected %h", p_out, {1'b1, 2'd2, 1'b0, 32'h0000_00C1});
        else passed++;
        set_lane(2, 1'b1, 32'h0000_00C2, 1'b1);
        tick();
        total++;
        if (p_out !== {1'b1, 2'd2, 1'b1, 32'h0000_00C2}) $display("FAIL lock_beat3: got %h expected %h", p_out, {1'b1, 2'd2, 1'b1, 32'h0000_00C2});
        else passed++;
        s_tvalid[2] = 1'b0;
        #1;
        total++;
        if (p_ready !== 4'b0001) $display("FAIL lock_release_ready: got %b expected %b", p_ready, 4'b0001);
        else passed++;
        tick();
        total++;
        if (p_out !== {1'b1, 2'd0, 1'b1, 32'h0000_00A0}) $display("FAIL lock_after0: got %h expected %h", p_out, {1'b1, 2'd0, 1'b1, 32'h0000_00A0});
        else passed++;
        s_tvalid[0] = 1'b0;
        tick();
        total++;
        if (p_out !== {1'b1, 2'd1, 1'b1, 32'h0000_00B0}) $display("FAIL lock_after1: got %h expected %h", p_out, {1'b1, 2'd1, 1'b1, 32'h0000_00B0});
        else passed++;
        s_tvalid = '0;
        tick();
        total++;
        if (p_valid !== 1'b0) $display("FAIL lock_drain: got %b expected %b", p_valid, 1'b0);
        else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        m_tready = 1'b0;
        set_lane(1, 1'b1, 32'hA5A5_A5A5, 1'b1);
        #1;
        total++;
        if (p_ready !== 4'b0010) $display("FAIL bp_first_ready: got %b expected %b", p_ready, 4'b0010);
        else passed++;
        tick();
        set_lane(1, 1'b1, 32'h5A5A_5A5A, 1'b1);
        for (int n = 0; n < 5; n++) begin
            total++;
            if (p_out !== {1'b1, 2'd1, 1'b1, 32'hA5A5_A5A5}) $display("FAIL bp_hold%0d: got %h expected %h", n, p_out, {1'b1, 2'd1, 1'b1, 32'hA5A5_A5A5});
            else passed++;
            #1;
            total++;
            if (p_ready !== 4'b0000) $display("FAIL bp_ready%0d: got %b expected %b", n, p_ready, 4'b0000);
            else passed++;
            tick();
        end
        m_tready = 1'b1;
        #1;
        total++;
        if (p_ready !== 4'b0010) $display("FAIL bp_resume_ready: got %b expected %b", p_ready, 4'b0010);
        else passed++;
        tick();
        total++;
        if (p_out !== {1'b1, 2'd1, 1'b1, 32'h5A5A_5A5A}) $display("FAIL bp_next_beat: got %h expected %h", p_out, {1'b1, 2'd1, 1'b1, 32'h5A5A_5A5A});
        else passed++;
        s_tvalid = '0;
        tick();
        total++;
        if (p_valid !== 1'b0) $display("FAIL bp_drain: got %b expected %b", p_valid, 1'b0);
        else passed++;
    endtask

    task automatic test_sparse();
        do_reset();
        set_lane(3, 1'b1, 32'h3333_0001, 1'b1);
        tick();
        total++;
        if (p_out !== {1'b1, 2'd3, 1'b1, 32'h3333_0001}) $display("FAIL sparse_l3a: got %h expected %h", p_out, {1'b1, 2'd3, 1'b1, 32'h3333_0001});
        else passed++;
        set_lane(3, 1'b1, 32'h3333_0002, 1'b1);
        tick();
        total++;
        if (p_out !== {1'b1, 2'd3, 1'b1, 32'h3333_0002}) $display("FAIL sparse_l3b: got %h expected %h", p_out, {1'b1, 2'd3, 1'b1, 32'h3333_0002});
        else passed++;
        s_tvalid[3] = 1'b0;
        set_lane(0, 1'b1, 32'h0000_00A1, 1'b1);
        tick();
        total++;
        if (p_out !== {1'b1, 2'd0, 1'b1, 32'h0000_00A1}) $display("FAIL sparse_l0: got %h expected %h", p_out, {1'b1, 2'd0, 1'b1, 32'h0000_00A1});
        else passed++;
        s_tvalid = '0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_lane(1, 1'b1, 32'h0000_00E0, 1'b0);
        tick();
        total++;
        if (p_out !== {1'b1, 2'd1, 1'b0, 32'h0000_00E0}) $display("FAIL rmid_beat1: got %h expected %h", p_out, {1'b1, 2'd1, 1'b0, 32'h0000_00E0});
        else passed++;
        set_lane(1, 1'b1, 32'h0000_00E1, 1'b0);
        set_lane(0, 1'b1, 32'h0000_00F0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (p_out !== 36'h0) $display("FAIL rmid_async_clear: got %h expected %h", p_out, 36'h0);
        else passed++;
        total++;
        if (p_ready !== 4'b0000) $display("FAIL rmid_ready: got %b expected %b", p_ready, 4'b0000);
        else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (p_ready !== 4'b0001) $display("FAIL rmid_restart_ready: got %b expected %b", p_ready, 4'b0001);
        else passed++;
        tick();
        total++;
        if (p_out !== {1'b1, 2'd0, 1'b1, 32'h0000_00F0}) $display("FAIL rmid_first_l0: got %h expected %h", p_out, {1'b1, 2'd0, 1'b1, 32'h0000_00F0});
        else passed++;
        s_tvalid[0] = 1'b0;
        tick();
        total++;
        if (p_out !== {1'b1, 2'd1, 1'b0, 32'h0000_00E1}) $display("FAIL rmid_then_l1: got %h expected %h", p_out, {1'b1, 2'd1, 1'b0, 32'h0000_00E1});
        else passed++;
        s_tvalid = '0;
        tick();
    endtask

    task automatic test_random();
        bit          pend [4];
        logic [31:0] pdata [4];
        bit          plast [4];
        int          pkt_left [4];
        int          seq [4];
        int          issued = 0;
        int          received = 0;
        bit          in_pkt = 0;
        logic [1:0]  pkt_lane = '0;
        bit          prev_stall = 0;
        logic [34:0] prev_out = '0;
        logic [32:0] got;
        logic [32:0] want;
        bit          busy;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0; plast[i] = 0; pdata[i] = '0; pkt_left[i] = 0; seq[i] = 0;
            exp_q[i].delete();
        end
        for (int c = 0; c < 40000; c++) begin
            busy = (issued < N_RAND) || (received != issued);
            for (int i = 0; i < 4; i++) begin
                busy = busy || pend[i] || (pkt_left[i] != 0);
                if (!pend[i] && (issued < N_RAND || pkt_left[i] != 0) && $urandom_range(0, 9) < 7) begin
                    if (pkt_left[i] == 0) pkt_left[i] = $urandom_range(1, 4);
                    pdata[i] = {2'(i), seq[i][29:0]};
                    plast[i] = (pkt_left[i] == 1);
                    pkt_left[i]--;
                    seq[i]++;
                    pend[i] = 1;
                    issued++;
                end
                set_lane(i, pend[i], pdata[i], plast[i]);
            end
            if (!busy) break;
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (s_tvalid[i] && p_ready[i]) begin
                    exp_q[i].push_back({plast[i], pdata[i]});
                    pend[i] = 0;
                end
            end
            if (prev_stall) begin
                total++;
                if ({p_valid, p_tid, p_last, p_data} !== {1'b1, prev_out})
                    $display("FAIL rand_stable: got %h expected %h", {p_valid, p_tid, p_last, p_data}, {1'b1, prev_out});
                else passed++;
            end
            prev_stall = p_valid && !m_tready;
            prev_out   = {p_tid, p_last, p_data};
            if (p_valid && m_tready) begin
                got = {p_last, p_data};
                want = '1;
                if (exp_q[p_tid].size() != 0) want = exp_q[p_tid].pop_front();
                total++;
                if (got !== want || (in_pkt && p_tid !== pkt_lane))
                    $display("FAIL rand_beat%0d: got tid %0d %h expected %h (pkt lane %0d open %0d)", received, p_tid, got, want, pkt_lane, in_pkt);
                else passed++;
                in_pkt   = !p_last;
                pkt_lane = p_tid;
                received++;
            end
            tick();
        end
        total++;
        if (received !== issued || issued < N_RAND)
            $display("FAIL rand_count: got %0d received expected %0d issued (min %0d)", received, issued, N_RAND);
        else passed++;
        s_tvalid = '0;
        m_tready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_rr_beat();
        test_packet_lock();
        test_backpressure();
        test_sparse();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/axis_merge4.md
Name: axis_merge4

Overview:
Merges four AXI-Stream slave lanes into one master stream, tagging each beat with its source lane on m_axis_tid.
Inverse of the tid-based 4-way split: its output can feed a 4-way splitter directly.
Round-robin arbitration, optional packet locking on tlast, one registered output stage, full throughput (1 beat/cycle).

Parameters:
DATA_W, 32, data width per lane and of the output
PKT_MODE, 1, 1 = hold grant until a beat with tlast=1 is accepted; 0 = re-arbitrate every beat

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
s_axis_tdata  input  DATA_W*4  lane i occupies bits [DATA_W*(i+1)-1 : DATA_W*i]
s_axis_tlast  input  4  per-lane end-of-packet
s_axis_tvalid  input  4  per-lane valid
s_axis_tready  output  4  per-lane ready
m_axis_tdata  output  DATA_W  merged data
m_axis_tid  output  2  source lane index of the current beat
m_axis_tlast  output  1  tlast of the current beat
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  downstream ready

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, m_axis_tlast=0, locked=0, grant=0, last_ptr=3 (lane 0 has first priority), s_axis_tready=0.
- State: output register (data/id/last/valid), locked flag, grant[1:0], last_ptr[1:0].
- load = ~m_axis_tvalid | m_axis_tready. This is the output stage accepting a new beat this cycle.
- Lane selection (combinational):
  - If locked: sel=grant.
  - Else: sel = first lane with tvalid=1, scanning last_ptr+1, last_ptr+2, last_ptr+3, last_ptr (mod 4). If no lane is valid, there is no selection.
- s_axis_tready[i] = load & (i==sel) & (locked | s_axis_tvalid[i]). All other lanes get ready=0. At most one bit of s_axis_tready is high.
- Transfer on lane sel when s_axis_tvalid[sel] & s_axis_tready[sel]. At the next edge:
  - m_axis_tdata is loaded from lane sel.
  - m_axis_tid <= sel, m_axis_tlast <= s_axis_tlast[sel], m_axis_tvalid <= 1.
- No transfer and m_axis_tready=1: m_axis_tvalid <= 0. Data, id and last are held; their value is don't-care.
- Output stable: while m_axis_tvalid=1 and m_axis_tready=0, the data, id and last outputs must not change.
- Latency: 1 cycle from input handshake to m_axis_tvalid. Back-to-back beats every cycle when m_axis_tready stays high.
- Arbitration update on each transfer:
  - PKT_MODE=1, tlast=0: locked <= 1, grant <= sel.
  - PKT_MODE=1, tlast=1: locked <= 0, last_ptr <= sel.
  - PKT_MODE=0: locked stays 0; last_ptr <= sel on every transfer.
- While locked, the granted lane deasserting tvalid stalls the merge. Other lanes wait and are never interleaved mid-packet.
- A single-beat packet (tlast=1 on its first beat) never sets locked.
- Simultaneous events: load and transfer in the same cycle as the downstream handshake give a seamless hand-over. Valid stays 1 and the new beat replaces the old one.
- Reset mid-packet: all state clears immediately, and any partially merged packet is dropped. After release, arbitration restarts from lane 0.
- tid width is fixed at 2; lane index i maps to tid value i.

Test Plan:
1. PKT_MODE=0, all 4 lanes valid continuously with tlast=1, m_axis_tready=1 -> m_axis_tid sequence 0,1,2,3,0,1,... with one beat per cycle and first m_axis_tvalid one cycle after the first handshake.
2. PKT_MODE=1, lane 2 sends a 3-beat packet (tlast on beat 3) while lanes 0 and 1 are valid -> three consecutive beats with tid=2 and tlast=0,0,1, then tid=0, then tid=1. No interleaving occurs even if lane 2 drops tvalid for 2 cycles mid-packet.
3. Backpressure: one beat D=0xA5A5A5A5 on lane 1, m_axis_tready held 0 for 5 cycles -> m_axis_tvalid=1 with data, tid=1 and last stable for all 5 cycles. s_axis_tready stays 0 for every lane until m_axis_tready=1. The next beat then flows without a bubble.
4. Sparse lanes: only lane 3 valid, then only lane 0 valid -> idle lanes are skipped with no dead cycle, and tid=3 is followed directly by tid=0.
5. Reset mid-packet: assert rst_n=0 after beat 1 of a 4-beat lane-1 packet -> outputs clear asynchronously (tvalid=0, tid=0, tlast=0). After release with lanes 0 and 1 valid, lane 0 is granted first.
6. Random stimulus with a scoreboard: random tvalid per lane, random m_axis_tready and random packet lengths, 10k beats -> per-lane data order is preserved, tid is correct on every beat, and no beat is lost or duplicated.
